// File: rtl/joybus_pak_crc_check.sv
// joybus_pak_crc_check: receive-side CRC-8 checker for Controller Pak
// blocks. Bit-serial N64 pak CRC (poly 0x85, MSB first, 8-bit zero flush).

module joybus_pak_crc_check #(
    parameter int BLOCK_BYTES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       byte_ready,
    input  logic       crc_valid,
    input  logic [7:0] crc_in,
    output logic       crc_ready,
    output logic       busy,
    output logic       done,
    output logic       crc_match,
    output logic [7:0] crc_calc
);

    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES);
    localparam logic [7:0] POLY = 8'h85;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SHIFT,
        S_FLUSH,
        S_WAIT_CRC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0]    r_crc;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic [CW-1:0] r_byte_cnt;
    logic          r_match;

    logic          w_byte_acc;
    logic          w_crc_acc;
    logic          w_step;
    logic          w_bit;
    logic [7:0]    w_tap;
    logic [7:0]    w_crc_next;
    logic          w_last_bit;
    logic          w_last_byte;

    assign w_last_bit  = (r_bit_cnt == 3'd7);
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // Data bit fed into the CRC: message bit in SHIFT, zero during FLUSH.
    assign w_bit      = (r_state == S_SHIFT) ? r_shift[7] : 1'b0;
    assign w_tap      = r_crc[7] ? POLY : 8'h00;
    assign w_crc_next = {r_crc[6:0], w_bit} ^ w_tap;

    assign crc_calc  = r_crc;
    assign crc_match = r_match;

    // State register; start restarts the block from any state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, handshake readies and status outputs.
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        crc_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_byte_acc   = 1'b0;
        w_crc_acc    = 1'b0;
        w_step       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_state_next = S_IDLE;
            end
            S_WAIT_BYTE: begin
                busy       = 1'b1;
                byte_ready = !start;
                w_byte_acc = byte_valid && !start;
                if (w_byte_acc) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last_bit) begin
                    w_state_next = w_last_byte ? S_FLUSH
                                               : S_WAIT_BYTE;
                end
            end
            S_FLUSH: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last_bit) begin
                    w_state_next = S_WAIT_CRC;
                end
            end
            S_WAIT_CRC: begin
                busy      = 1'b1;
                crc_ready = !start;
                w_crc_acc = crc_valid && !start;
                if (w_crc_acc) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (start) begin
            w_state_next = S_WAIT_BYTE;
            w_step       = 1'b0;
        end
    end

    // CRC, shift register, counters and registered match result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_crc      <= 8'h00;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
            r_match    <= 1'b0;
        end else if (start) begin
            r_crc      <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
            r_match    <= 1'b0;
        end else begin
            if (w_byte_acc) begin
                r_shift    <= byte_in;
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= r_byte_cnt + CW'(1);
            end
            if (w_step) begin
                r_crc     <= w_crc_next;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_state == S_SHIFT) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                end
            end
            if (w_crc_acc) begin
                r_match <= (crc_in == r_crc);
            end
        end
    end

endmodule

// File: tb/tb_joybus_pak_crc_check.sv
// tb_joybus_pak_crc_check: randomized checks of the pak CRC checker
// against a polynomial-remainder reference model.

module tb_joybus_pak_crc_check;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       crc_valid;
    logic [7:0] crc_in;

    logic       a_byte_ready, a_crc_ready, a_busy, a_done, a_crc_match;
    logic [7:0] a_crc_calc;
    logic       b_byte_ready, b_crc_ready, b_busy, b_done, b_crc_match;
    logic [7:0] b_crc_calc;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int a_done_n = 0;
    int b_done_n = 0;
    int a_bh = 0;
    int a_ch = 0;

    logic [7:0] pw [0:700];

    joybus_pak_crc_check #(.BLOCK_BYTES(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .byte_valid(byte_valid), .byte_in(byte_in),
        .byte_ready(a_byte_ready),
        .crc_valid(crc_valid), .crc_in(crc_in),
        .crc_ready(a_crc_ready), .busy(a_busy), .done(a_done),
        .crc_match(a_crc_match), .crc_calc(a_crc_calc)
    );

    joybus_pak_crc_check #(.BLOCK_BYTES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .byte_valid(byte_valid), .byte_in(byte_in),
        .byte_ready(b_byte_ready),
        .crc_valid(crc_valid), .crc_in(crc_in),
        .crc_ready(b_crc_ready), .busy(b_busy), .done(b_done),
        .crc_match(b_crc_match), .crc_calc(b_crc_calc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (a_done) a_done_n++;
            if (b_done) b_done_n++;
            if (byte_valid && a_byte_ready) a_bh++;
            if (crc_valid && a_crc_ready) a_ch++;
        end
    end

    // CRC = (M(x) * x^8) mod (x^8 + 0x85), built by linearity from x^k mod P.
    function automatic logic [7:0] model_crc(input logic [7:0] d[$]);
        logic [7:0] r;
        int n;
        r = 8'h00;
        n = d.size() * 8;
        for (int i = 0; i < n; i++) begin
            if (d[i/8][7-(i%8)]) r ^= pw[n - 1 - i + 8];
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b,
                             input int gap, input bit keep,
                             output int acc);
        bit ok;
        bit rdy;
        ok = 1'b0;
        byte_valid = keep;
        repeat (gap) cyc();
        byte_in = b;
        byte_valid = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            #1;
            rdy = sel ? b_byte_ready : a_byte_ready;
            cyc();
            if (rdy) ok = 1'b1;
        end
        acc = cyc_n;
        byte_valid = keep;
        byte_in = 8'($urandom);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL byte_timeout got=no_ready want=ready");
        end
    endtask

    task automatic send_crc(input bit sel, input logic [7:0] c,
                            output int acc);
        bit ok;
        bit rdy;
        ok = 1'b0;
        crc_in = c;
        crc_valid = 1'b1;
        for (int n = 0; n < 60 && !ok; n++) begin
            #1;
            rdy = sel ? b_crc_ready : a_crc_ready;
            cyc();
            if (rdy) ok = 1'b1;
        end
        acc = cyc_n;
        crc_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL crc_timeout got=no_ready want=ready");
        end
    endtask

    task automatic send_block(input bit sel, input logic [7:0] d[$],
                              input int maxgap, input bit keep,
                              output int last_acc);
        int g;
        int acc;
        acc = 0;
        foreach (d[i]) begin
            g = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
            send_byte(sel, d[i], g, keep, acc);
        end
        last_acc = acc;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        int dn;
        int acc;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start      = 1'($urandom);
            byte_valid = 1'($urandom);
            byte_in    = 8'($urandom);
            crc_valid  = 1'($urandom);
            crc_in     = 8'($urandom);
            cyc();
            #1;
            got = {a_byte_ready, a_crc_ready, a_busy, a_done,
                   a_crc_match, a_crc_calc};
            total++;
            if (got !== 13'h0) begin
                bad++;
                $display("FAIL reset_a got=%h want=0", got);
            end
            got = {b_byte_ready, b_crc_ready, b_busy, b_done,
                   b_crc_match, b_crc_calc};
            total++;
            if (got !== 13'h0) begin
                bad++;
                $display("FAIL reset_b got=%h want=0", got);
            end
        end
        start = 0; byte_valid = 0; crc_valid = 0;
        reset_n = 1'b1;
        cyc();
        pulse_start();
        dn = a_done_n;
        for (int i = 0; i < 5; i++) send_byte(0, 8'($urandom), 0, 0, acc);
        reset_n = 1'b0;
        cyc();
        #1;
        got = {a_byte_ready, a_crc_ready, a_busy, a_done,
               a_crc_match, a_crc_calc};
        total++;
        if (got !== 13'h0) begin
            bad++;
            $display("FAIL reset_midblock got=%h want=0", got);
        end
        reset_n = 1'b1;
        repeat (20) cyc();
        total++;
        if (a_done_n !== dn || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_nodone got=%0d/%b want=%0d/0",
                     a_done_n, a_busy, dn);
        end
    endtask

    task automatic test_zero_block();
        logic [7:0] d[$];
        logic [7:0] c;
        logic [7:0] want;
        int last;
        int acc;
        int dn;
        for (int rep = 0; rep < 2; rep++) begin
            d = {};
            for (int i = 0; i < 32; i++) d.push_back(8'h00);
            want = model_crc(d);
            c = (rep == 0) ? 8'h00 : 8'h01;
            pulse_start();
            #1;
            total++;
            if ({a_byte_ready, a_busy, a_crc_calc} !== 10'h300) begin
                bad++;
                $display("FAIL zero_start got=%b%b%h want=1100",
                         a_byte_ready, a_busy, a_crc_calc);
            end
            send_block(0, d, 0, 0, last);
            dn = a_done_n;
            send_crc(0, c, acc);
            total++;
            if (acc - last !== 17) begin
                bad++;
                $display("FAIL zero_crc_lat got=%0d want=17", acc - last);
            end
            #1;
            total++;
            if (a_done !== 1'b1 || a_crc_calc !== want ||
                a_crc_calc !== 8'h00) begin
                bad++;
                $display("FAIL zero_done got=%b/%h want=1/%h",
                         a_done, a_crc_calc, want);
            end
            total++;
            if (a_crc_match !== (c == want)) begin
                bad++;
                $display("FAIL zero_match got=%b want=%b",
                         a_crc_match, (c == want));
            end
            cyc();
            #1;
            total++;
            if (a_done !== 1'b0 || a_busy !== 1'b0 ||
                a_done_n !== dn + 1 || a_crc_match !== (c == want)) begin
                bad++;
                $display("FAIL zero_after got=%b%b%0d want=00%0d",
                         a_done, a_busy, a_done_n, dn + 1);
            end
        end
    endtask

    task automatic test_single_bit();
        logic [7:0] vin  [0:3];
        logic [7:0] vexp [0:3];
        logic [7:0] d[$];
        logic [7:0] want;
        logic [7:0] c;
        int last;
        int acc;
        vin[0] = 8'h01; vexp[0] = 8'h85;
        vin[1] = 8'h80; vexp[1] = 8'h89;
        vin[2] = 8'($urandom); vexp[2] = 8'h00;
        vin[3] = 8'($urandom); vexp[3] = 8'h00;
        for (int j = 0; j < 4; j++) begin
            d = {vin[j]};
            want = model_crc(d);
            c = (j == 3) ? (want ^ 8'h40) : want;
            pulse_start();
            send_block(1, d, 0, 0, last);
            send_crc(1, c, acc);
            #1;
            total++;
            if (b_done !== 1'b1 || b_crc_calc !== want ||
                b_crc_match !== (j != 3)) begin
                bad++;
                $display("FAIL single_%0d got=%b/%h/%b want=1/%h/%b",
                         j, b_done, b_crc_calc, b_crc_match, want, j != 3);
            end
            if (j < 2) begin
                total++;
                if (b_crc_calc !== vexp[j]) begin
                    bad++;
                    $display("FAIL single_vec_%0d got=%h want=%h",
                             j, b_crc_calc, vexp[j]);
                end
            end
            cyc();
        end
    endtask

    task automatic test_leading_zeros();
        logic [7:0] d[$];
        int g;
        int acc;
        int prev;
        int want;
        int last;
        for (int rep = 0; rep < 2; rep++) begin
            d = {};
            for (int i = 0; i < 31; i++) d.push_back(8'h00);
            d.push_back(8'h01);
            pulse_start();
            prev = 0;
            for (int i = 0; i < 32; i++) begin
                g = (rep == 0) ? 0 : int'($urandom_range(0, 12));
                send_byte(0, d[i], g, 0, acc);
                if (i > 0) begin
                    want = (g + 1 > 9) ? g + 1 : 9;
                    total++;
                    if (acc - prev !== want) begin
                        bad++;
                        $display("FAIL lz_latency got=%0d want=%0d",
                                 acc - prev, want);
                    end
                end
                prev = acc;
            end
            last = acc;
            send_crc(0, 8'h85, acc);
            #1;
            total++;
            if (a_crc_calc !== 8'h85 || a_crc_calc !== model_crc(d) ||
                a_crc_match !== 1'b1 || a_done !== 1'b1) begin
                bad++;
                $display("FAIL lz_result got=%h/%b want=85/1",
                         a_crc_calc, a_crc_match);
            end
            total++;
            if (acc - last !== 17) begin
                bad++;
                $display("FAIL lz_crc_lat got=%0d want=17", acc - last);
            end
            cyc();
        end
    endtask

    task automatic test_random_blocks();
        logic [7:0] d[$];
        logic [7:0] want;
        logic [7:0] c;
        bit corrupt;
        int last;
        int acc;
        for (int rep = 0; rep < 4; rep++) begin
            d = {};
            for (int i = 0; i < 32; i++) d.push_back(8'($urandom));
            want = model_crc(d);
            corrupt = (rep % 2) == 1;
            c = corrupt ? (want ^ (8'h01 << $urandom_range(0, 7))) : want;
            pulse_start();
            send_block(0, d, 3, 0, last);
            send_crc(0, c, acc);
            #1;
            total++;
            if (a_crc_calc !== want || a_crc_match !== !corrupt) begin
                bad++;
                $display("FAIL rand_%0d got=%h/%b want=%h/%b",
                         rep, a_crc_calc, a_crc_match, want, !corrupt);
            end
            cyc();
        end
    endtask

    task automatic test_abort();
        logic [7:0] d[$];
        int dn;
        int ch0;
        int acc;
        int last;
        int n;
        pulse_start();
        dn = a_done_n;
        for (int i = 0; i < 10; i++) send_byte(0, 8'($urandom), 0, 0, acc);
        cyc(); cyc(); cyc();
        start = 1'b1;
        #1;
        total++;
        if (a_byte_ready !== 1'b0 || a_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_shift got=%b%b want=01",
                     a_byte_ready, a_busy);
        end
        cyc();
        start = 1'b0;
        #1;
        total++;
        if (a_crc_calc !== 8'h00 || a_byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart got=%h/%b want=00/1",
                     a_crc_calc, a_byte_ready);
        end
        d = {};
        for (int i = 0; i < 32; i++) d.push_back(8'($urandom));
        send_block(0, d, 0, 0, last);
        crc_in = model_crc(d);
        crc_valid = 1'b1;
        n = 0;
        #1;
        while (!a_crc_ready && n < 40) begin
            cyc();
            #1;
            n++;
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL abort_wait got=%0d want=16", n);
        end
        ch0 = a_ch;
        start = 1'b1;
        #1;
        total++;
        if (a_crc_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_crc_ready got=%b want=0", a_crc_ready);
        end
        cyc();
        start = 1'b0;
        crc_valid = 1'b0;
        #1;
        total++;
        if (a_done !== 1'b0 || a_crc_calc !== 8'h00 || a_busy !== 1'b1 ||
            a_byte_ready !== 1'b1 || a_ch !== ch0) begin
            bad++;
            $display("FAIL abort_crc got=%b/%h/%b/%b want=0/00/1/1",
                     a_done, a_crc_calc, a_busy, a_byte_ready);
        end
        d = {};
        for (int i = 0; i < 32; i++) d.push_back(8'h00);
        send_block(0, d, 0, 0, last);
        send_crc(0, 8'h00, acc);
        #1;
        total++;
        if (acc - last !== 17 || a_done !== 1'b1 ||
            a_crc_match !== 1'b1) begin
            bad++;
            $display("FAIL abort_clean got=%0d/%b/%b want=17/1/1",
                     acc - last, a_done, a_crc_match);
        end
        cyc();
        total++;
        if (a_done_n !== dn + 1) begin
            bad++;
            $display("FAIL abort_done_count got=%0d want=%0d",
                     a_done_n, dn + 1);
        end
    endtask

    task automatic test_stray();
        logic [7:0] d[$];
        logic [7:0] want;
        int ch0;
        int bh0;
        int last;
        int acc;
        d = {};
        for (int i = 0; i < 32; i++) d.push_back(8'($urandom));
        want = model_crc(d);
        pulse_start();
        ch0 = a_ch;
        bh0 = a_bh;
        crc_valid = 1'b1;
        crc_in = 8'($urandom);
        send_block(0, d, 0, 1, last);
        total++;
        if (a_ch !== ch0) begin
            bad++;
            $display("FAIL stray_crc_early got=%0d want=%0d", a_ch, ch0);
        end
        send_crc(0, want, acc);
        #1;
        total++;
        if (acc - last !== 17) begin
            bad++;
            $display("FAIL stray_crc_lat got=%0d want=17", acc - last);
        end
        total++;
        if (a_bh !== bh0 + 32 || a_ch !== ch0 + 1) begin
            bad++;
            $display("FAIL stray_counts got=%0d/%0d want=%0d/%0d",
                     a_bh, a_ch, bh0 + 32, ch0 + 1);
        end
        total++;
        if (a_crc_calc !== want || a_crc_match !== 1'b1 ||
            a_done !== 1'b1) begin
            bad++;
            $display("FAIL stray_result got=%h/%b want=%h/1",
                     a_crc_calc, a_crc_match, want);
        end
        byte_valid = 1'b0;
        cyc();
    endtask

    initial begin
        logic [8:0] p;
        p = 9'h001;
        for (int k = 0; k <= 700; k++) begin
            pw[k] = p[7:0];
            p = p << 1;
            if (p[8]) p = p ^ 9'h185;
        end
        reset_n = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        crc_valid = 1'b0;
        crc_in = 8'h00;
        test_reset();
        test_zero_block();
        test_single_bit();
        test_leading_zeros();
        test_random_blocks();
        test_abort();
        test_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/joybus_pak_crc_check.md
# joybus_pak_crc_check

Receive-side CRC-8 checker for Controller Pak data blocks on the joybus path. Consumes the data bytes of one block (32 by default) through a valid/ready stream, then consumes the CRC byte returned by the far end. Computes the N64 pak CRC bit-serially: polynomial 0x85, MSB first, followed by an 8-zero-bit flush. Reports match/mismatch to the controller-channel sequencer, so the sequencer can accept a pak read or retry it.

## Interface
Parameters:
- BLOCK_BYTES, 32, data bytes per block; legal range 1..64.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; clears CRC and byte count and begins a new block; accepted in any state.
- byte_valid  in  1  byte_in is valid.
- byte_in  in  8  block data byte.
- byte_ready  out  1  checker accepts byte_in this cycle.
- crc_valid  in  1  crc_in is valid.
- crc_in  in  8  received CRC byte from the far end.
- crc_ready  out  1  checker accepts crc_in this cycle.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse: comparison finished.
- crc_match  out  1  registered result; valid from done until the next start.
- crc_calc  out  8  running/final computed CRC register.

## Operation
- States: IDLE, WAIT_BYTE, SHIFT, FLUSH, WAIT_CRC, DONE.
- IDLE: outputs quiescent. start -> WAIT_BYTE; CRC=0x00, byte count=0, crc_match=0, busy=1.
- WAIT_BYTE: byte_ready = !start.
  - On byte_valid && byte_ready: latch byte into shift register, clear bit counter to 0, increment byte count -> SHIFT.
- SHIFT: one bit per cycle, MSB first, 8 cycles.
  - Per bit b: tap = CRC[7] ? 0x85 : 0x00; CRC <= {CRC[6:0], b} ^ tap.
  - After the 8th bit: if byte count == BLOCK_BYTES -> FLUSH, else -> WAIT_BYTE.
- FLUSH: same per-bit update with b=0, 8 cycles -> WAIT_CRC.
- WAIT_CRC: crc_ready = !start.
  - On crc_valid && crc_ready: crc_match <= (crc_in == CRC) -> DONE.
- DONE: done=1 for exactly this cycle, busy=0 -> IDLE.
- start in any state, including mid-SHIFT/FLUSH or the same cycle as a valid handshake:
  - Aborts the current block; no handshake completes that cycle; reinitialises as from IDLE.
  - No done pulse for the aborted block.
- byte_valid/crc_valid outside their accept states are ignored; no error flag. A crc_valid during byte phases is not latched.
- Byte count width ceil(log2(BLOCK_BYTES+1)); bit counter 3 bits, never wraps into byte state.
- crc_calc = CRC register at all times. It holds the final value from WAIT_CRC until the next start.

## Timing
- Reset (reset_n=0 at a clock edge): state IDLE, byte_ready=0, crc_ready=0, busy=0, done=0, crc_match=0, crc_calc=0x00. Reset mid-block discards everything.
- start edge -> byte_ready high the next cycle.
- Byte accept -> byte_ready high again 9 cycles later (8 SHIFT + return). Maximum throughput is 1 byte per 9 cycles.
- Last byte accept -> crc_ready high 17 cycles later (8 SHIFT + 8 FLUSH + 1).
- CRC accept -> done and valid crc_match on the next cycle. Total block (32 bytes, zero-wait source) = 1 + 32×9 + 8 + 1 + 1 cycles from start to done.
- byte_ready and crc_ready are combinational from state and start only; no dependency on the valid inputs.

## Test plan
- Reset check: hold reset_n low 3 cycles with random inputs -> all outputs at reset values, no handshake ever accepted.
- Zero block: start, 32 × 0x00, crc_in=0x00 -> crc_calc=0x00, done pulse 1 cycle, crc_match=1. Repeat with crc_in=0x01 -> crc_match=0.
- Single-bit vectors (BLOCK_BYTES=1):
  - byte 0x01 -> crc_calc=0x85.
  - byte 0x80 -> crc_calc=0x89.
  - crc_in equal to the computed value -> crc_match=1.
- Leading zeros: 31 × 0x00 then 0x01 -> crc_calc=0x85, match with crc_in=0x85. Insert random byte_valid gaps; the result must not change and per-byte latency is exactly 9 cycles when valid is held.
- Abort: start pulsed during SHIFT of byte 10, and again coincident with a WAIT_CRC handshake -> no done for the aborted block, crc_calc=0x00, byte count restarts. The following clean zero block matches.
- Stray inputs: crc_valid held high throughout the byte phase, byte_valid high during WAIT_CRC -> neither accepted early. The result equals the clean run, and crc_ready first rises exactly 17 cycles after the last byte accept.
